cpu_bus_responder: RTL
======================

# cpu_bus_responder

Return path of the CPU memory bus. It consumes the per-target enables produced by the address decoder and collects read data and completion from the RAM, VDP, status, DSP and flash targets. It drives the single-cycle `cpu_mem_ready` pulse and the registered `cpu_mem_rdata` back to the CPU. A watchdog bounds variable-latency accesses, and a sticky error flag reports bus faults.

## Interface
- `TIMEOUT_CYCLES`, default 255: WAIT cycles allowed for VDP/flash before a forced response. Legal range is 1..255.
- `ERROR_RDATA`, default 32'hFFFF_FFFF: read data returned on a timed-out read.

Ports:
- `clk` in 1: the single system clock.
- `reset` in 1: asynchronous, active-high.
- `cpu_mem_valid` in 1: CPU request valid.
- `cpu_wstrb` in 4: nonzero means write.
- `cpu_ram_en`, `vdp_en`, `status_en`, `dsp_en`, `flash_read_en` in 1 each: one-hot target select from the decoder.
- `cpu_ram_rdata`, `status_rdata`, `dsp_rdata` in 32 each: fixed-latency targets, valid the cycle after the enable is first seen.
- `vdp_rdata` in 32, `vdp_ready` in 1: variable-latency target.
- `flash_rdata` in 32, `flash_ready` in 1: variable-latency target.
- `bus_error_clear` in 1: clears `bus_error`.
- `cpu_mem_ready` out 1: one-cycle completion pulse.
- `cpu_mem_rdata` out 32: registered response data.
- `bus_error` out 1: sticky fault flag.

## Operation
- States:
  - IDLE: accepts a request.
  - WAIT: waits on the target.
  - DONE: `cpu_mem_ready`=1 for exactly one cycle.
- IDLE:
  - Transition: when `cpu_mem_valid` and exactly one enable are high, go to WAIT.
  - Latched at that edge: the target ID, the write flag (`|cpu_wstrb`), and 0 into the wait counter.
  - No action: valid with no enable high (reset gating), or with more than one enable high.
- WAIT, fixed target (RAM/status/DSP):
  - Unconditionally go to DONE on the next edge.
  - Read: capture the target rdata into `cpu_mem_rdata`.
  - Write: load 0 into `cpu_mem_rdata`.
- WAIT, VDP:
  - When `vdp_ready`=1, go to DONE.
  - Read: capture `vdp_rdata`. Write: load 0.
- WAIT, flash read:
  - When `flash_ready`=1, go to DONE and capture `flash_rdata`.
- WAIT, flash write:
  - Flash is read-only, so no wait: go to DONE on the next edge.
  - Load 0 into rdata and set `bus_error`.
- Watchdog:
  - Counter (8 bit) increments each WAIT cycle for VDP/flash reads and VDP writes.
  - When counter == `TIMEOUT_CYCLES - 1` and the target ready is low, go to DONE and set `bus_error`.
  - Data on timeout: rdata = `ERROR_RDATA` for reads, 0 for writes.
  - Target ready in the same cycle as the timeout: ready wins, with normal capture and no error.
- DONE:
  - Next state is always IDLE.
  - Requests seen during DONE are ignored. The CPU drops valid after ready, so the next request can only be accepted in IDLE.
- `cpu_mem_rdata` changes only on a WAIT→DONE capture edge and holds between responses.
- `bus_error`:
  - Set by a flash write or a timeout; cleared by `bus_error_clear`.
  - Set and clear in the same cycle: set wins.

## Timing
- Reset (async, any state) values:
  - state IDLE
  - `cpu_mem_ready`=0
  - `cpu_mem_rdata`=0
  - `bus_error`=0
  - counter=0
  - latched target/write flag cleared
- Fixed targets: valid seen in cycle 0 (IDLE), WAIT in cycle 1, ready=1 with data in cycle 2. Latency is 2.
- Variable targets: target ready sampled high in WAIT cycle N, then ready=1 in cycle N+1. Minimum latency is 2, when target ready is already high in cycle 1.
- Timeout: ready asserts `TIMEOUT_CYCLES`+1 cycles after acceptance.
- `bus_error` rises in the same cycle as the faulting `cpu_mem_ready`.
- Back-to-back requests: next acceptance no earlier than the cycle after DONE, i.e. at least 3 cycles per access.
- Reset mid-WAIT: the transaction is dropped and no ready is issued. The target's late ready after reset is ignored in IDLE.

## Test plan
- RAM read:
  - Stimulus: valid+`cpu_ram_en`, wstrb=0, `cpu_ram_rdata`=32'h1234_5678 in cycle 1.
  - Required: ready=1 only in cycle 2, rdata=32'h1234_5678, `bus_error`=0.
- VDP read:
  - Stimulus: `vdp_ready` rises 5 cycles after acceptance with `vdp_rdata`=32'h0000_ABCD.
  - Required: single ready pulse 6 cycles after acceptance, rdata=32'h0000_ABCD.
- Flash timeout:
  - Stimulus: `TIMEOUT_CYCLES`=4, flash read, `flash_ready` held low.
  - Required: ready 5 cycles after acceptance, rdata=32'hFFFF_FFFF, `bus_error`=1 until `bus_error_clear`.
- Flash write:
  - Stimulus: `flash_read_en`, wstrb=4'b1111.
  - Required: ready at cycle 2, rdata=0, `bus_error`=1. Then `bus_error_clear` together with a second flash write: `bus_error` stays 1.
- Timeout boundary:
  - Stimulus: `TIMEOUT_CYCLES`=4, `vdp_ready` first high in the final allowed WAIT cycle.
  - Required: normal capture, `bus_error`=0.
- Reset mid-WAIT:
  - Stimulus: assert `reset` during a VDP wait, then release; `vdp_ready` pulses afterwards.
  - Required: outputs 0 immediately on reset, no `cpu_mem_ready`, next RAM read completes with latency 2.

Source files
------------

// File: rtl/cpu_bus_responder_if.sv
// rtl/cpu_bus_responder_if.sv - CPU memory bus return-path signal bundle
interface cpu_bus_responder_if;
   logic        cpu_mem_valid;
   logic [3:0]  cpu_wstrb;
   logic        cpu_ram_en;
   logic        vdp_en;
   logic        status_en;
   logic        dsp_en;
   logic        flash_read_en;
   logic [31:0] cpu_ram_rdata;
   logic [31:0] status_rdata;
   logic [31:0] dsp_rdata;
   logic [31:0] vdp_rdata;
   logic        vdp_ready;
   logic [31:0] flash_rdata;
   logic        flash_ready;
   logic        bus_error_clear;
   logic        cpu_mem_ready;
   logic [31:0] cpu_mem_rdata;
   logic        bus_error;

   modport master (
      output cpu_mem_valid, cpu_wstrb,
      output cpu_ram_en, vdp_en, status_en, dsp_en, flash_read_en,
      output cpu_ram_rdata, status_rdata, dsp_rdata,
      output vdp_rdata, vdp_ready, flash_rdata, flash_ready,
      output bus_error_clear,
      input  cpu_mem_ready, cpu_mem_rdata, bus_error
   );

   modport slave (
      input  cpu_mem_valid, cpu_wstrb,
      input  cpu_ram_en, vdp_en, status_en, dsp_en, flash_read_en,
      input  cpu_ram_rdata, status_rdata, dsp_rdata,
      input  vdp_rdata, vdp_ready, flash_rdata, flash_ready,
      input  bus_error_clear,
      output cpu_mem_ready, cpu_mem_rdata, bus_error
   );
endinterface

// File: rtl/cpu_bus_responder.sv
// rtl/cpu_bus_responder.sv - CPU bus response FSM with watchdog and sticky fault flag
module cpu_bus_responder #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter logic [31:0] ERROR_RDATA    = 32'hFFFF_FFFF
) (
   input  logic                clk,
   input  logic                reset,
   cpu_bus_responder_if.slave  bus
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_DONE
   } state_e;

   typedef enum logic [2:0] {
      TGT_NONE,
      TGT_RAM,
      TGT_VDP,
      TGT_STATUS,
      TGT_DSP,
      TGT_FLASH
   } target_e;

   localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

   state_e      state_q, state_d;
   target_e     target_q, target_d;
   logic        write_q, write_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        ready_q, ready_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;
   logic        err_set;

   logic [4:0]  en_vec;
   logic        en_one_hot;
   target_e     sel_target;
   logic [31:0] fixed_rdata;
   logic        var_ready;
   logic [31:0] var_rdata;

   assign en_vec = {bus.cpu_ram_en, bus.vdp_en, bus.status_en, bus.dsp_en, bus.flash_read_en};
   assign en_one_hot = (en_vec != 5'd0) && ((en_vec & (en_vec - 5'd1)) == 5'd0);

   always_comb begin
      sel_target = TGT_NONE;
      if (bus.cpu_ram_en)         sel_target = TGT_RAM;
      else if (bus.vdp_en)        sel_target = TGT_VDP;
      else if (bus.status_en)     sel_target = TGT_STATUS;
      else if (bus.dsp_en)        sel_target = TGT_DSP;
      else if (bus.flash_read_en) sel_target = TGT_FLASH;
   end

   always_comb begin
      fixed_rdata = 32'd0;
      case (target_q)
         TGT_RAM:    fixed_rdata = bus.cpu_ram_rdata;
         TGT_STATUS: fixed_rdata = bus.status_rdata;
         TGT_DSP:    fixed_rdata = bus.dsp_rdata;
         default:    fixed_rdata = 32'd0;
      endcase
   end

   assign var_ready = (target_q == TGT_VDP) ? bus.vdp_ready : bus.flash_ready;
   assign var_rdata = (target_q == TGT_VDP) ? bus.vdp_rdata : bus.flash_rdata;

   always_comb begin
      state_d  = state_q;
      target_d = target_q;
      write_d  = write_q;
      cnt_d    = cnt_q;
      ready_d  = 1'b0;
      rdata_d  = rdata_q;
      err_set  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.cpu_mem_valid && en_one_hot) begin
               state_d  = ST_WAIT;
               target_d = sel_target;
               write_d  = |bus.cpu_wstrb;
               cnt_d    = 8'd0;
            end
         end

         ST_WAIT: begin
            case (target_q)
               TGT_RAM, TGT_STATUS, TGT_DSP: begin
                  state_d = ST_DONE;
                  ready_d = 1'b1;
                  rdata_d = write_q ? 32'd0 : fixed_rdata;
               end
               TGT_VDP, TGT_FLASH: begin
                  // Flash is read-only: a write is faulted immediately, without waiting.
                  if (target_q == TGT_FLASH && write_q) begin
                     state_d = ST_DONE;
                     ready_d = 1'b1;
                     rdata_d = 32'd0;
                     err_set = 1'b1;
                  end else if (var_ready) begin
                     state_d = ST_DONE;
                     ready_d = 1'b1;
                     rdata_d = write_q ? 32'd0 : var_rdata;
                  end else if (cnt_q == LAST_WAIT) begin
                     state_d = ST_DONE;
                     ready_d = 1'b1;
                     rdata_d = write_q ? 32'd0 : ERROR_RDATA;
                     err_set = 1'b1;
                  end else begin
                     cnt_d = cnt_q + 8'd1;
                  end
               end
               default: state_d = ST_IDLE;
            endcase
         end

         ST_DONE: state_d = ST_IDLE;

         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      err_d = err_q;
      if (bus.bus_error_clear) err_d = 1'b0;
      if (err_set)             err_d = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         target_q <= TGT_NONE;
         write_q  <= 1'b0;
         cnt_q    <= 8'd0;
         ready_q  <= 1'b0;
         rdata_q  <= 32'd0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         target_q <= target_d;
         write_q  <= write_d;
         cnt_q    <= cnt_d;
         ready_q  <= ready_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   assign bus.cpu_mem_ready = ready_q;
   assign bus.cpu_mem_rdata = rdata_q;
   assign bus.bus_error     = err_q;

endmodule
